demux1_8_tdm: RTL and testbench

Time-division 1:8 demultiplexer: the receive end of an 8:1 time-multiplexed link built from our mux trees. A serial stream of WIDTH-bit beats, framed by a start-of-frame marker, is unpacked into eight registered parallel outputs. A complete frame is published atomically with a one-cycle `frame_valid` pulse. The block sits directly after the link register, on the far side of an 8:1 select path.

---
 rtl/demux1_8_tdm_pkg.sv | 15 +
 rtl/demux1_8_tdm_dec3_8.sv | 20 ++
 rtl/demux1_8_tdm.sv | 209 ++++++++++++++++++++
 tb/tb_demux1_8_tdm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux1_8_tdm_pkg.sv
// demux_pkg: shared definitions for the demux1_8_tdm slice.
//   SLOTS   - number of time slots per frame (fan-out of the demux)
//   SEL_W   - width of the slot index
//   state_t - framing FSM states
package demux_pkg;

  localparam int SLOTS = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/demux1_8_tdm_dec3_8.sv
// dec3_8: combinational 3-bit to one-hot 8 decoder with enable.
// Drives the shadow-slot write enables of demux1_8_tdm.
// Ports:
//   en     - decoder enable; all outputs low when en is low
//   idx    - slot index to select
//   onehot - one-hot write enables, bit idx set when en is high
module dec3_8
  import demux_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] idx,
  output logic [SLOTS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/demux1_8_tdm.sv
// demux1_8_tdm: receive end of an 8:1 time-multiplexed link. Serial WIDTH-bit
// beats framed by a start-of-frame marker are unpacked into eight registered
// parallel outputs, published atomically with a one-cycle frame_valid pulse.
//
// Optional feature (macro DEMUX_SOF_CHECK_EN):
//   defined   - sof is checked on every accepted beat in LOCK; violations
//               pulse sync_err and resynchronise or drop lock.
//   undefined - sof only acquires lock from HUNT; sync_err is tied low.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   din         - beat data (WIDTH bits)
//   din_valid   - beat present this cycle
//   sof         - start-of-frame, qualified by din_valid
//   y0..y7      - last complete frame, slot k on yk
//   frame_valid - one-cycle pulse when y0..y7 update
//   sel         - slot index the next accepted beat will fill
//   locked      - high while framed (state LOCK)
//   sync_err    - one-cycle pulse per framing violation
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | not framed; beats discarded until a valid sof beat arrives
// LOCK  | framed; each accepted beat fills slot sel, sel advances mod 8
module demux1_8_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic             frame_valid,
  output logic [SEL_W-1:0] sel,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SLOTS - 1);

  state_t           state_q, state_n;
  logic [SEL_W-1:0] sel_q, sel_n;

  logic             wr_en;
  logic [SEL_W-1:0] wr_idx;
  logic [SLOTS-1:0] we;
  logic             err_n;

  // Slot 7 never needs a shadow: it goes straight from din into y7.
  logic [WIDTH-1:0] shadow_q [SLOTS-1];
  logic [WIDTH-1:0] y_q      [SLOTS];
  logic             frame_valid_q;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sel_q   <= '0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    case (state_q)
      HUNT: begin
        if (din_valid && sof) begin
          state_n = LOCK;
          sel_n   = SEL_ONE;
        end
      end
      LOCK: begin
        if (din_valid) begin
`ifdef DEMUX_SOF_CHECK_EN
          if (sof && (sel_q != '0)) begin
            // Early sof: restart the frame with this beat as slot 0.
            sel_n = SEL_ONE;
          end else if (!sof && (sel_q == '0)) begin
            state_n = HUNT;
            sel_n   = '0;
          end else begin
            sel_n = sel_q + SEL_ONE;
          end
`else
          sel_n = sel_q + SEL_ONE;
`endif
        end
      end
      default: begin
        state_n = HUNT;
        sel_n   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: shadow write request and framing error
  // ---------------------------------------------------------------------
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sel_q;
    err_n  = 1'b0;
    case (state_q)
      HUNT: begin
        if (din_valid && sof) begin
          wr_en  = 1'b1;
          wr_idx = '0;
        end
      end
      LOCK: begin
        if (din_valid) begin
`ifdef DEMUX_SOF_CHECK_EN
          if (sof && (sel_q != '0)) begin
            err_n  = 1'b1;
            wr_en  = 1'b1;
            wr_idx = '0;
          end else if (!sof && (sel_q == '0)) begin
            err_n = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
`else
          wr_en = 1'b1;
`endif
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  dec3_8 u_dec (
    .en     (wr_en),
    .idx    (wr_idx),
    .onehot (we)
  );

  // ---------------------------------------------------------------------
  // Shadow slots, published outputs and frame pulse.
  // we[SLOTS-1] is the slot-7 write, which is also the frame-complete event.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS - 1; i++) shadow_q[i] <= '0;
      for (int i = 0; i < SLOTS; i++)     y_q[i]      <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        if (we[i]) shadow_q[i] <= din;
      end
      if (we[SLOTS-1]) begin
        for (int i = 0; i < SLOTS - 1; i++) y_q[i] <= shadow_q[i];
        y_q[SLOTS-1] <= din;
      end
      frame_valid_q <= we[SLOTS-1];
    end
  end

`ifdef DEMUX_SOF_CHECK_EN
  logic sync_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_err_q <= 1'b0;
    else        sync_err_q <= err_n;
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign y4          = y_q[4];
  assign y5          = y_q[5];
  assign y6          = y_q[6];
  assign y7          = y_q[SLOTS-1];
  assign frame_valid = frame_valid_q;
  assign sel         = sel_q;
  assign locked      = (state_q == LOCK);

  // Unused in the default build; kept so the decoder's full width is visible.
  logic unused_last;
  assign unused_last = (SEL_LAST == sel_q) & 1'b0;

endmodule

// File: tb/tb_demux1_8_tdm.sv
// tb_demux1_8_tdm: directed self-checking bench for demux1_8_tdm (WIDTH=1).
// Expected frames are hand-packed as {y7..y0}. Builds with or without
// DEMUX_SOF_CHECK_EN and checks the behaviour matching the build.
module tb_demux1_8_tdm;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic       y0, y1, y2, y3, y4, y5, y6, y7;
  logic       frame_valid;
  logic [2:0] sel;
  logic       locked;
  logic       sync_err;

  int n_checks = 0;
  int n_errors = 0;
  int fv_cnt   = 0;
  int err_cnt  = 0;
  int fv_mark;
  int err_mark;

  demux1_8_tdm #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .y4          (y4),
    .y5          (y5),
    .y6          (y6),
    .y7          (y7),
    .frame_valid (frame_valid),
    .sel         (sel),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (sync_err === 1'b1)    err_cnt++;
  end

  function automatic logic [7:0] yv();
    return {y7, y6, y5, y4, y3, y2, y1, y0};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic d, input logic s);
    din       = d;
    din_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full frame, sof on slot 0, bits[k] lands on yk.
  task automatic send_frame(input logic [7:0] bits);
    for (int k = 0; k < 8; k++) beat(bits[k], k == 0);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    #12;
    check("reset_y", yv(), 8'h00);
    check("reset_fv", {7'd0, frame_valid}, 8'd0);
    check("reset_locked", {7'd0, locked}, 8'd0);
    check("reset_sel", {5'd0, sel}, 8'd0);
    check("reset_err", {7'd0, sync_err}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sof without din_valid in HUNT is ignored
    sof = 1'b1; idle(1); sof = 1'b0;
    check("hunt_sof_novalid_locked", {7'd0, locked}, 8'd0);

    // Frame A: 1,0,1,1,0,0,1,0
    pat = 8'h4D;
    fv_mark = fv_cnt;
    beat(pat[0], 1'b1);
    check("a_locked", {7'd0, locked}, 8'd1);
    check("a_sel1", {5'd0, sel}, 8'd1);
    for (int k = 1; k < 7; k++) beat(pat[k], 1'b0);
    check("a_pre_y", yv(), 8'h00);
    check("a_pre_fv", {7'd0, frame_valid}, 8'd0);
    beat(pat[7], 1'b0);
    check("a_y", yv(), 8'h4D);
    check("a_fv", {7'd0, frame_valid}, 8'd1);
    check("a_sel_wrap", {5'd0, sel}, 8'd0);
    idle(1);
    check("a_fv_once", {7'd0, frame_valid}, 8'd0);
    check("a_hold", yv(), 8'h4D);
    check("a_fv_cnt", 8'(fv_cnt - fv_mark), 8'd1);

    // Frame B with a 3-cycle gap between slots 4 and 5
    pat = 8'h96;
    fv_mark = fv_cnt;
    for (int k = 0; k < 5; k++) beat(pat[k], k == 0);
    sof = 1'b1; idle(1); sof = 1'b0;   // sof without valid in LOCK
    idle(2);
    check("b_gap_sel", {5'd0, sel}, 8'd5);
    check("b_gap_y", yv(), 8'h4D);
    check("b_gap_err", {7'd0, sync_err}, 8'd0);
    for (int k = 5; k < 8; k++) beat(pat[k], 1'b0);
    check("b_y", yv(), 8'h96);
    idle(2);
    check("b_fv_cnt", 8'(fv_cnt - fv_mark), 8'd1);

    // Back to HUNT, unframed beats ignored, then framed frame C
    rst_n = 1'b0; #2; rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < 3; k++) beat(1'b1, 1'b0);
    check("c_hunt_locked", {7'd0, locked}, 8'd0);
    check("c_hunt_sel", {5'd0, sel}, 8'd0);
    check("c_hunt_y", yv(), 8'h00);
    send_frame(8'hA5);
    check("c_y", yv(), 8'hA5);
    check("c_locked", {7'd0, locked}, 8'd1);

    // Slot 0 without sof
    err_mark = err_cnt;
    beat(1'b1, 1'b0);
`ifdef DEMUX_SOF_CHECK_EN
    check("s0_err", {7'd0, sync_err}, 8'd1);
    check("s0_locked", {7'd0, locked}, 8'd0);
    check("s0_sel", {5'd0, sel}, 8'd0);
    idle(1);
    check("s0_err_once", 8'(err_cnt - err_mark), 8'd1);
    send_frame(8'h3C);
    check("s0_relock_y", yv(), 8'h3C);
`else
    check("s0_err", {7'd0, sync_err}, 8'd0);
    check("s0_locked", {7'd0, locked}, 8'd1);
    check("s0_sel", {5'd0, sel}, 8'd1);
    pat = 8'h3D;
    for (int k = 1; k < 8; k++) beat(pat[k], 1'b0);
    check("s0_y", yv(), 8'h3D);
`endif

    // sof on slot 5 of the next frame
    err_mark = err_cnt;
    fv_mark  = fv_cnt;
    for (int k = 0; k < 5; k++) beat(1'b1, k == 0);
    beat(1'b0, 1'b1);
`ifdef DEMUX_SOF_CHECK_EN
    check("rs_err", {7'd0, sync_err}, 8'd1);
    check("rs_sel", {5'd0, sel}, 8'd1);
    check("rs_locked", {7'd0, locked}, 8'd1);
    check("rs_hold", yv(), 8'h3C);
    pat = 8'h5A;
    for (int k = 1; k < 7; k++) beat(pat[k], 1'b0);
    check("rs_pre_fv", 8'(fv_cnt - fv_mark), 8'd0);
    check("rs_pre_y", yv(), 8'h3C);
    beat(pat[7], 1'b0);
    check("rs_y", yv(), 8'h5A);
    check("rs_fv", {7'd0, frame_valid}, 8'd1);
    check("rs_err_once", 8'(err_cnt - err_mark), 8'd1);
`else
    check("rs_err", {7'd0, sync_err}, 8'd0);
    check("rs_sel", {5'd0, sel}, 8'd6);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    check("rs_y", yv(), 8'hDF);
    check("rs_fv", {7'd0, frame_valid}, 8'd1);
    check("rs_err_cnt", 8'(err_cnt - err_mark), 8'd0);
`endif

    // Asynchronous reset after 4 beats of a frame
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_y", yv(), 8'h00);
    check("ar_locked", {7'd0, locked}, 8'd0);
    check("ar_sel", {5'd0, sel}, 8'd0);
    check("ar_fv", {7'd0, frame_valid}, 8'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(8'hC3);
    check("ar_after_y", yv(), 8'hC3);
    check("ar_after_fv", {7'd0, frame_valid}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
